// File: rtl/debounce_bank_if.sv
// Switch-side bundle of the debouncer bank: raw levels in, clean levels and edge pulses out.
// The master drives the raw inputs; the debouncer is the slave.
interface debounce_bank_if #(
  parameter int N = 4
);
  logic [N-1:0] din;
  logic [N-1:0] dout;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic         any_chg;

  modport master (
    output din,
    input  dout,
    input  rise,
    input  fall,
    input  any_chg
  );

  modport slave (
    input  din,
    output dout,
    output rise,
    output fall,
    output any_chg
  );
endinterface

// File: rtl/debounce_bank.sv
// N-channel switch debouncer: per-channel synchroniser, shared sample prescaler,
// per-channel stability counter, registered level plus one-clock rise/fall pulses.
module debounce_bank #(
  parameter int N           = 4,
  parameter int DIV         = 4,
  parameter int STABLE      = 3,
  parameter int SYNC_STAGES = 2,
  parameter bit RST_VAL     = 1'b0
) (
  input logic            clk,
  input logic            rst,
  debounce_bank_if.slave bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = (STABLE > 1) ? $clog2(STABLE) : 1;
  localparam logic [PW-1:0] PC_LAST  = PW'(DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

  logic [SYNC_STAGES-1:0] sync_q [N];
  logic [N-1:0]           s;

  logic [PW-1:0] pc;
  logic          tick;

  logic [CW-1:0] cnt_q   [N];
  logic [CW-1:0] cnt_nxt [N];
  logic [N-1:0]  dout_q;
  logic [N-1:0]  dout_nxt;
  logic [N-1:0]  rise_q;
  logic [N-1:0]  rise_nxt;
  logic [N-1:0]  fall_q;
  logic [N-1:0]  fall_nxt;
  logic          any_q;

  // Only the last flop of each chain is ever looked at downstream.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        sync_q[i] <= {SYNC_STAGES{RST_VAL}};
      end else begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.din[i]};
      end
    end
  end

  always_comb begin
    s = '0;
    for (int i = 0; i < N; i++) begin
      s[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // With DIV=1 the counter is pinned at zero, so every cycle is a sample tick.
  assign tick = (pc == PC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else if (tick) begin
      pc <= '0;
    end else begin
      pc <= pc + PW'(1);
    end
  end

  always_comb begin
    dout_nxt = dout_q;
    rise_nxt = '0;
    fall_nxt = '0;
    for (int i = 0; i < N; i++) begin
      cnt_nxt[i] = cnt_q[i];
    end
    if (tick) begin
      for (int i = 0; i < N; i++) begin
        if (s[i] == dout_q[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          dout_nxt[i] = s[i];
          cnt_nxt[i]  = '0;
          rise_nxt[i] = s[i];
          fall_nxt[i] = ~s[i];
        end else begin
          cnt_nxt[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Pulses are registered alongside dout so they line up with the level change.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= {N{RST_VAL}};
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      dout_q <= dout_nxt;
      rise_q <= rise_nxt;
      fall_q <= fall_nxt;
      any_q  <= |(rise_nxt | fall_nxt);
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_nxt[i];
      end
    end
  end

  assign bus.dout    = dout_q;
  assign bus.rise    = rise_q;
  assign bus.fall    = fall_q;
  assign bus.any_chg = any_q;

endmodule
